fl_div_32bit_seq: RTL and testbench

- Multi-cycle IEEE-754 single-precision divider; companion (inverse operation) to the combinational fl_mul_32bit multiplier in the Lab 2 floating-point datapath.
- Computes in0 / in1 with a restoring mantissa divider, one quotient bit per clock.
- Start/done handshake, so it can sit behind the multiplier in the same lab datapath or be driven directly by a bench.

---
 rtl/fl_div_32bit_seq.sv | 157 +++++++++++++++
 tb/tb_fl_div_32bit_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fl_div_32bit_seq.sv
// Sequential binary32 divider: restoring mantissa division, one quotient bit per clock,
// truncating rounding, denormals flushed to zero, start/done handshake.
module fl_div_32bit_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic [31:0] quotient,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [25:0] rem_q, rem_d;
  logic [23:0] div_q, div_d;
  logic [24:0] q_q, q_d;
  logic [4:0]  count_q, count_d;
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [31:0] quot_q, quot_d;
  logic        dbz_q, dbz_d;
  logic        inv_q, inv_d;
  logic        done_q, done_d;
  logic [34:0] spec;

  // Returns {is_special, invalid, div_by_zero, result}; checks are in priority order.
  function automatic logic [34:0] special_case(input logic [31:0] a, input logic [31:0] b);
    logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    s      = a[31] ^ b[31];
    nan_a  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    nan_b  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    inf_a  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    inf_b  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    zero_a = (a[30:23] == 8'h00);
    zero_b = (b[30:23] == 8'h00);
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b))
      return {3'b110, 32'h7fc00000};
    else if (inf_a)  return {3'b100, s, 8'hff, 23'd0};
    else if (inf_b)  return {3'b100, s, 31'd0};
    else if (zero_b) return {3'b101, s, 8'hff, 23'd0};
    else if (zero_a) return {3'b100, s, 31'd0};
    else             return {3'b000, 32'd0};
  endfunction

  // Normalise the 25-bit quotient, truncate, and saturate exponent to inf or zero.
  function automatic logic [31:0] norm_pack(input logic s, input logic [7:0] ea,
                                            input logic [7:0] eb, input logic [24:0] q);
    logic signed [9:0] e;
    logic [22:0]       f;
    f = q[24] ? q[23:1] : q[22:0];
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + (q[24] ? 10'sd127 : 10'sd126);
    if (e >= 10'sd255)    return {s, 8'hff, 23'd0};
    else if (e <= 10'sd0) return {s, 31'd0};
    else                  return {s, e[7:0], f};
  endfunction

  assign spec = special_case(in0, in1);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    count_d = count_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    quot_d  = quot_q;
    dbz_d   = dbz_q;
    inv_d   = inv_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = in0[31] ^ in1[31];
          ea_d   = in0[30:23];
          eb_d   = in1[30:23];
          if (spec[34]) begin
            quot_d  = spec[31:0];
            inv_d   = spec[33];
            dbz_d   = spec[32];
            state_d = S_DONE;
          end else begin
            rem_d   = {2'b01, in0[22:0], 1'b0} >> 1;
            div_d   = {1'b1, in1[22:0]};
            q_d     = 25'd0;
            count_d = 5'd24;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        // Quotient bits shift in from the bottom, so the first bit ends up in q[24].
        q_d     = {q_q[23:0], (rem_q >= {2'b00, div_q})};
        rem_d   = ((rem_q >= {2'b00, div_q}) ? (rem_q - {2'b00, div_q}) : rem_q) << 1;
        count_d = count_q - 5'd1;
        if (count_q == 5'd0) state_d = S_NORM;
      end
      S_NORM: begin
        quot_d  = norm_pack(sign_q, ea_q, eb_q, q_q);
        dbz_d   = 1'b0;
        inv_d   = 1'b0;
        state_d = S_DONE;
      end
      default: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= 26'd0;
      div_q   <= 24'd0;
      q_q     <= 25'd0;
      count_q <= 5'd0;
      sign_q  <= 1'b0;
      ea_q    <= 8'd0;
      eb_q    <= 8'd0;
      quot_q  <= 32'd0;
      dbz_q   <= 1'b0;
      inv_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      count_q <= count_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      quot_q  <= quot_d;
      dbz_q   <= dbz_d;
      inv_q   <= inv_d;
      done_q  <= done_d;
    end
  end

  assign quotient    = quot_q;
  assign busy        = (state_q == S_DIV) || (state_q == S_NORM);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule

// File: tb/tb_fl_div_32bit_seq.sv
// Scoreboard bench for fl_div_32bit_seq: driver pushes model results, monitor pops on done.
module tb_fl_div_32bit_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in0 = 32'd0;
  logic [31:0] in1 = 32'd0;
  logic [31:0] quotient;
  logic        busy, done, div_by_zero, invalid;

  fl_div_32bit_seq dut (
    .clk(clk), .rst(rst), .start(start), .in0(in0), .in1(in1),
    .quotient(quotient), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .invalid(invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        special;
    logic        inv;
    logic        dbz;
    logic [31:0] q;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  // Reference: real-valued rules on integers (mantissa ratio scaled by 2^24, truncated).
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    logic   s;
    int     ea, eb, e;
    longint fa, fb, ma, mb, qq, f;
    bit     nan_a, nan_b, inf_a, inf_b, z_a, z_b;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = longint'(a[22:0]); fb = longint'(b[22:0]);
    nan_a = (ea == 255) && (fa != 0); nan_b = (eb == 255) && (fb != 0);
    inf_a = (ea == 255) && (fa == 0); inf_b = (eb == 255) && (fb == 0);
    z_a = (ea == 0); z_b = (eb == 0);
    r = '0;
    r.special = 1'b1;
    if (nan_a || nan_b || (z_a && z_b) || (inf_a && inf_b)) begin
      r.q = 32'h7fc00000; r.inv = 1'b1;
    end else if (inf_a) r.q = {s, 8'hff, 23'd0};
    else if (inf_b)     r.q = {s, 31'd0};
    else if (z_b) begin r.q = {s, 8'hff, 23'd0}; r.dbz = 1'b1; end
    else if (z_a)       r.q = {s, 31'd0};
    else begin
      r.special = 1'b0;
      ma = fa + 64'd8388608;
      mb = fb + 64'd8388608;
      qq = (ma * 64'd16777216) / mb;
      if (qq >= 64'd16777216) begin f = (qq / 2) % 64'd8388608; e = ea - eb + 127; end
      else begin f = qq % 64'd8388608; e = ea - eb + 126; end
      if (e >= 255)    r.q = {s, 8'hff, 23'd0};
      else if (e <= 0) r.q = {s, 31'd0};
      else             r.q = {s, 8'(e), 23'(f)};
    end
    return r;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        chk("invalid", {31'd0, invalid}, {31'd0, e.inv});
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit restart);
    exp_t e;
    int   n, busy_cnt, lat;
    e   = model(a, b);
    lat = e.special ? 1 : 27;
    in0 = a; in1 = b; start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      if (restart && n == 9) begin in0 = 32'h41000000; start = 1'b1; end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    chk("latency", n, lat);
    chk("busy_cycles", busy_cnt, e.special ? 0 : 26);
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0]  ex;
    logic [22:0] fr;
    int          r;
    r  = $urandom_range(0, 11);
    fr = 23'($urandom);
    if (r == 0)      ex = 8'd0;
    else if (r == 1) begin ex = 8'hff; if ($urandom_range(0, 1) == 1) fr = 23'd0; end
    else if (r == 2) ex = 8'($urandom_range(1, 254));
    else             ex = 8'($urandom_range(100, 154));
    return {1'($urandom), ex, fr};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_flags", {29'd0, busy, done, div_by_zero | invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(32'h40000000, 32'h40000000, 1'b0);
    run_op(32'h41000000, 32'h40000000, 1'b0);
    run_op(32'hc1f00000, 32'h41f00000, 1'b0);
    run_op(32'h42f00000, 32'h41f00000, 1'b0);
    run_op(32'h3f800000, 32'h40400000, 1'b0);
    run_op(32'h7f000000, 32'h00800000, 1'b0);
    run_op(32'h00800000, 32'h4f000000, 1'b0);
    run_op(32'h3f800000, 32'h00000000, 1'b0);
    run_op(32'h00000000, 32'h00000000, 1'b0);
    run_op(32'h7f800000, 32'h3f800000, 1'b0);
    run_op(32'hbf800000, 32'hff800000, 1'b0);
    run_op(32'h7fc00001, 32'h3f800000, 1'b0);
    run_op(32'h40000000, 32'h40000000, 1'b1);

    for (int i = 0; i < 30; i++) run_op(rnd_fp(), rnd_fp(), 1'b0);

    // Abort a division midway with an asynchronous reset.
    in0 = 32'h40000000; in1 = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("async_rst_quotient", quotient, 32'd0);
    chk("async_rst_flags", {29'd0, busy, done, div_by_zero | invalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(32'h40000000, 32'h40000000, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
